iquant: RTL and testbench

IQUANT -- requirements
Module: iquant

---
 rtl/iquant_pkg.sv | 26 ++
 rtl/iquant_sat.sv | 15 +
 rtl/iquant.sv | 49 ++++
 tb/tb_iquant.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/iquant_pkg.sv
// iquant_pkg: shared widths, saturation limits, stage types and the coefficient multiply for iquant.
package iquant_pkg;
  localparam int COEF_W = 12;
  localparam int Q_W = 8;
  localparam int PROD_W = 20;
  localparam int OUT_W = 16;
  localparam int BLK_N = 64;
  localparam int IDX_W = $clog2(BLK_N);
  localparam logic signed [PROD_W-1:0] SAT_MAX = PROD_W'(32767);
  localparam logic signed [PROD_W-1:0] SAT_MIN = PROD_W'(-32768);
  typedef logic [IDX_W-1:0] idx_t;
  typedef struct packed {
    logic v;
    idx_t idx;
    logic signed [COEF_W-1:0] coef;
  } s1_t;
  typedef struct packed {
    logic v;
    idx_t idx;
    logic signed [OUT_W-1:0] coef;
  } s2_t;
  // Signed coef times unsigned matrix entry; the low PROD_W bits of the extended product are exact.
  function automatic logic signed [PROD_W-1:0] mul(input logic signed [COEF_W-1:0] c, input logic [Q_W-1:0] q);
    return {{(PROD_W-COEF_W){c[COEF_W-1]}}, c} * {{(PROD_W-Q_W){1'b0}}, q};
  endfunction
endpackage

// File: rtl/iquant_sat.sv
// iquant_sat: 20->16 bit product reduction; clamps when IQUANT_SAT_EN is defined, wraps otherwise.
module iquant_sat
  import iquant_pkg::*;
(
  input  logic signed [PROD_W-1:0] prod_i,
  output logic signed [OUT_W-1:0]  coef_o
);
`ifdef IQUANT_SAT_EN
  always_comb coef_o = prod_i > SAT_MAX ? OUT_W'(SAT_MAX) : prod_i < SAT_MIN ? OUT_W'(SAT_MIN) : prod_i[OUT_W-1:0];
`else
  logic unused_hi;
  assign unused_hi = ^prod_i[PROD_W-1:OUT_W];
  always_comb coef_o = prod_i[OUT_W-1:0];
`endif
endmodule

// File: rtl/iquant.sv
// iquant: two-stage dequantizer, out = in_coef x romq[idx], reduced to 16 bits.
// Define IQUANT_SAT_EN to saturate the product; otherwise it wraps.
module iquant
  import iquant_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [11:0] in_coef,
  output logic [5:0]  rom_a,
  input  logic [7:0]  rom_d,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_coef,
  output logic        out_last
);
  idx_t idx_q, idx_d;
  s1_t s1_q, s1_d;
  s2_t s2_q, s2_d;
  logic stall, acc;
  logic signed [PROD_W-1:0] prod;
  logic signed [OUT_W-1:0] red;
  assign stall = s2_q.v && !out_ready;
  assign acc = in_valid && !stall;
  assign prod = mul(s1_q.coef, rom_d);
  iquant_sat u_sat (.prod_i(prod), .coef_o(red));
  always_comb begin
    idx_d = acc ? idx_q + 1'b1 : idx_q;
    s1_d = stall ? s1_q : s1_t'{v: acc, idx: idx_q, coef: in_coef};
    s2_d = stall ? s2_q : s2_t'{v: s1_q.v, idx: s1_q.idx, coef: red};
  end
  // While stalled, re-read S1's entry so rom_d is still correct when S1 finally advances.
  assign rom_a = (stall && s1_q.v) ? s1_q.idx : idx_q;
  assign in_ready = !stall;
  assign out_valid = s2_q.v;
  assign out_coef = s2_q.coef;
  assign out_last = s2_q.v && s2_q.idx == IDX_W'(BLK_N-1);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      idx_q <= '0;
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      idx_q <= idx_d;
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
endmodule

// File: tb/tb_iquant.sv
// tb_iquant: directed and randomized self-checking bench for iquant against a queue-based dequantizer model.
`timescale 1ns/1ps
module tb_iquant;
  logic clk = 0, rst = 1, in_valid = 0, in_ready, out_valid, out_ready = 1, out_last;
  logic [11:0] in_coef = 0;
  logic [5:0] rom_a;
  logic [7:0] rom_d = 0;
  logic [15:0] out_coef;
  int n_chk = 0, n_fail = 0, cyc = 0, m_idx = 0;
  int exp_q[$], last_q[$], tin_q[$];
  int got[$], got_last[$], got_lat[$];
  logic stall_p = 0;
  logic [15:0] prev_coef = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  iquant dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_coef(in_coef),
    .rom_a(rom_a), .rom_d(rom_d), .out_valid(out_valid), .out_ready(out_ready),
    .out_coef(out_coef), .out_last(out_last)
  );

  function automatic int qv(int i);
    return i < 63 ? i + 1 : 255;
  endfunction

  always @(posedge clk) rom_d <= 8'(qv(int'(rom_a)));

  function automatic int reduce(int p);
`ifdef IQUANT_SAT_EN
    return p > 32767 ? 32767 : p < -32768 ? -32768 : p;
`else
    logic signed [15:0] w;
    w = p[15:0];
    return w;
`endif
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      last_q.delete();
      tin_q.delete();
      m_idx = 0;
      stall_p = 0;
    end else begin
      chk("in_ready", in_ready, !(out_valid && !out_ready));
      if (out_last) chk("last_without_valid", out_valid, 1);
      if (stall_p) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_coef", $signed(out_coef), $signed(prev_coef));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("spurious_out", 1, 0);
        else begin
          int e, l, t;
          e = exp_q.pop_front();
          l = last_q.pop_front();
          t = tin_q.pop_front();
          chk("out_coef", $signed(out_coef), e);
          chk("out_last", out_last, l);
          got.push_back($signed(out_coef));
          got_last.push_back(out_last);
          got_lat.push_back(cyc - t);
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(reduce($signed(in_coef) * qv(m_idx)));
        last_q.push_back(m_idx == 63);
        tin_q.push_back(cyc);
        m_idx = (m_idx + 1) % 64;
      end
      stall_p = out_valid && !out_ready;
      prev_coef = out_coef;
    end
  end

  task automatic clear_log();
    got.delete();
    got_last.delete();
    got_lat.delete();
  endtask

  task automatic send(input logic [11:0] c);
    int n = 0;
    in_valid = 1;
    in_coef = c;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      $display("FAIL send_timeout: in_ready stuck low");
      $fatal(1, "send timeout");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 300) begin
      n++;
      @(negedge clk);
    end
    chk("drain_timeout", n < 300, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_rom_a", rom_a, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_out_valid2", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_coef", out_coef, 0);
    chk("rst_rom_a2", rom_a, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    clear_log();
    for (int i = 0; i < 64; i++) send(12'd5);
    in_valid = 0;
    drain();
    chk("blk5_count", got.size(), 64);
    for (int i = 0; i < 64 && i < got.size(); i++) begin
      chk("blk5_coef", got[i], i < 63 ? 5 * (i + 1) : 1275);
      chk("blk5_last", got_last[i], i == 63);
      chk("blk5_latency", got_lat[i], 2);
    end
    clear_log();
    for (int i = 0; i < 64; i++) send(i == 1 ? 12'hFFD : i == 63 ? 12'h7FF : 12'h000);
    in_valid = 0;
    drain();
    chk("edge_count", got.size(), 64);
    if (got.size() == 64) begin
      chk("neg3_idx1", got[1], -6);
`ifdef IQUANT_SAT_EN
      chk("max_idx63", got[63], 32767);
`else
      chk("max_idx63", got[63], -2303);
`endif
      for (int i = 2; i < 63; i++) chk("zero_coef", got[i], 0);
    end
    clear_log();
    fork
      begin
        for (int i = 0; i < 64; i++) send(12'd3);
        in_valid = 0;
      end
      begin
        int n = 0;
        while (got.size() < 10 && n < 500) begin
          @(posedge clk);
          #1;
          n++;
        end
        out_ready = 0;
        repeat (5) begin
          @(negedge clk);
          chk("stall_in_ready", in_ready, 0);
          chk("stall_valid", out_valid, 1);
          chk("stall_coef", $signed(out_coef), 33);
        end
        @(posedge clk);
        #1 out_ready = 1;
      end
    join
    drain();
    chk("stall_count", got.size(), 64);
    for (int i = 0; i < 64 && i < got.size(); i++) begin
      chk("stall_blk_coef", got[i], i < 63 ? 3 * (i + 1) : 765);
      chk("stall_blk_last", got_last[i], i == 63);
    end
    for (int i = 0; i < 20; i++) send(12'(100 + i));
    in_valid = 0;
    rst = 1;
    @(negedge clk);
    chk("midrst_valid", out_valid, 0);
    chk("midrst_rom_a", rom_a, 0);
    @(posedge clk);
    #1 rst = 0;
    clear_log();
    @(negedge clk);
    chk("midrst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    send(12'd7);
    for (int i = 0; i < 63; i++) send(12'd1);
    in_valid = 0;
    drain();
    chk("midrst_count", got.size(), 64);
    if (got.size() == 64) begin
      chk("midrst_first", got[0], 7);
      chk("midrst_first_last", got_last[0], 0);
      chk("midrst_last63", got_last[63], 1);
      for (int i = 1; i < 63; i++) chk("midrst_no_last", got_last[i], 0);
    end
    for (int b = 0; b < 900; b++) begin
      int r;
      r = $urandom_range(0, 7);
      in_valid = ($urandom_range(0, 3) != 0);
      in_coef = r == 0 ? 12'h7FF : r == 1 ? 12'h800 : r == 2 ? 12'h000 : 12'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
    in_valid = 0;
    out_ready = 1;
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
